// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM core / dead-time stages.
package pwm_pkg;

  // Counter width used by pwm_core_ip for its period counter.
  localparam int unsigned CNT_WIDTH = 16;

  // Dead-time count width and reset dead time for pwm_deadtime_ip.
  localparam int unsigned DT_WIDTH_DEFAULT = 8;
  localparam int unsigned DEADTIME_DEFAULT = 2;

  // Gate sequencing states: both off, low on, low->high gap, high on, high->low gap.
  typedef enum logic [2:0] {
    DT_IDLE    = 3'd0,
    DT_L_ON    = 3'd1,
    DT_DEAD_LH = 3'd2,
    DT_H_ON    = 3'd3,
    DT_DEAD_HL = 3'd4
  } dt_state_t;

endpackage : pwm_pkg

// File: rtl/pwm_dt_shadow.sv
// Shadow register for the dead time; clamps 0 to 1 so the gates never switch on one edge.
module pwm_dt_shadow
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH                = DT_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DEADTIME_CYCLES = DEADTIME_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [DT_WIDTH-1:0] dt_req,
  output logic [DT_WIDTH-1:0] dt_active
);

  logic [DT_WIDTH-1:0] dt_eff_c;
  logic [DT_WIDTH-1:0] dt_active_d;
  logic [DT_WIDTH-1:0] dt_active_q;

  // Clamp request and pick next shadow value.
  always_comb begin
    dt_eff_c    = (dt_req == '0) ? DT_WIDTH'(1) : dt_req;
    dt_active_d = dt_active_q;
    if (load_en) begin
      dt_active_d = dt_eff_c;
    end
  end

  // Shadow register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_active_q <= DT_WIDTH'(DEFAULT_DEADTIME_CYCLES);
    end else begin
      dt_active_q <= dt_active_d;
    end
  end

  assign dt_active = dt_active_q;

endmodule : pwm_dt_shadow

// File: rtl/pwm_deadtime_ip.sv
// Complementary gate generator with break-before-make dead time after pwm_core_ip.
module pwm_deadtime_ip
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH                = DT_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DEADTIME_CYCLES = DEADTIME_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                pwm_raw,
  input  logic                period_end,
  input  logic [DT_WIDTH-1:0] deadtime_cycles_i,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                in_deadtime,
  output logic [DT_WIDTH-1:0] dt_active,
  output logic                short_pulse
);

  dt_state_t           state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                pwm_h_q, pwm_h_d;
  logic                pwm_l_q, pwm_l_d;
  logic                in_dt_q, in_dt_d;
  logic                short_q, short_d;
  logic                shadow_load_c;

  // Shadow reloads at enabled period boundaries and continuously while idle.
  assign shadow_load_c = (period_end & enable) | (state_q == DT_IDLE);

  pwm_dt_shadow #(
    .DT_WIDTH                (DT_WIDTH),
    .DEFAULT_DEADTIME_CYCLES (DEFAULT_DEADTIME_CYCLES)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .load_en   (shadow_load_c),
    .dt_req    (deadtime_cycles_i),
    .dt_active (dt_active)
  );

  // Next state, dead-time counter and output decode from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    if (!enable) begin
      state_d = DT_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DT_IDLE: begin
          state_d = pwm_raw ? DT_H_ON : DT_L_ON;
        end
        DT_L_ON: begin
          if (pwm_raw) begin
            state_d = DT_DEAD_LH;
            cnt_d   = dt_active - DT_WIDTH'(1);
          end
        end
        DT_DEAD_LH: begin
          if (!pwm_raw) begin
            state_d = DT_L_ON;
            short_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = DT_H_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        DT_H_ON: begin
          if (!pwm_raw) begin
            state_d = DT_DEAD_HL;
            cnt_d   = dt_active - DT_WIDTH'(1);
          end
        end
        DT_DEAD_HL: begin
          if (pwm_raw) begin
            state_d = DT_H_ON;
            short_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = DT_L_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = DT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    pwm_l_d = (state_d == DT_L_ON);
    pwm_h_d = (state_d == DT_H_ON);
    in_dt_d = (state_d == DT_DEAD_LH) || (state_d == DT_DEAD_HL);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DT_IDLE;
      cnt_q   <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
      in_dt_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
      in_dt_q <= in_dt_d;
      short_q <= short_d;
    end
  end

  assign pwm_h       = pwm_h_q;
  assign pwm_l       = pwm_l_q;
  assign in_deadtime = in_dt_q;
  assign short_pulse = short_q;

  // Shoot-through guard: both gates must never be on together.
  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(pwm_h_q && pwm_l_q));

endmodule : pwm_deadtime_ip

// File: tb/tb_pwm_deadtime_ip.sv
// Randomized and directed bench for pwm_deadtime_ip against a phase-level reference model.
module tb_pwm_deadtime_ip;

  localparam int unsigned DTW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           pwm_raw;
  logic           period_end;
  logic [DTW-1:0] deadtime_cycles_i;
  logic           pwm_h;
  logic           pwm_l;
  logic           in_deadtime;
  logic [DTW-1:0] dt_active;
  logic           short_pulse;

  always #5 clk = ~clk;

  pwm_deadtime_ip #(
    .DT_WIDTH                (DTW),
    .DEFAULT_DEADTIME_CYCLES (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .pwm_raw           (pwm_raw),
    .period_end        (period_end),
    .deadtime_cycles_i (deadtime_cycles_i),
    .pwm_h             (pwm_h),
    .pwm_l             (pwm_l),
    .in_deadtime       (in_deadtime),
    .dt_active         (dt_active),
    .short_pulse       (short_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which gate is on, and the edge number at which a pending gap ends.
  // phase: 0 off, 1 low on, 2 gap toward high, 3 high on, 4 gap toward low.
  int m_phase;
  int m_dt;
  int m_edge;
  int m_gap_end;
  int m_short;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_dt      = 2;
    m_edge    = 0;
    m_gap_end = 0;
    m_short   = 0;
  endtask

  // One clock edge of the model using the inputs currently driven.
  task automatic model_step();
    int  old_dt;
    bit  load;
    old_dt  = m_dt;
    load    = (period_end && enable) || (m_phase == 0);
    m_short = 0;
    m_edge++;
    if (!enable) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_phase = pwm_raw ? 3 : 1;
    end else if (m_phase == 1 && pwm_raw) begin
      m_phase = 2; m_gap_end = m_edge + old_dt;
    end else if (m_phase == 3 && !pwm_raw) begin
      m_phase = 4; m_gap_end = m_edge + old_dt;
    end else if (m_phase == 2) begin
      if (!pwm_raw) begin m_phase = 1; m_short = 1; end
      else if (m_edge == m_gap_end) m_phase = 3;
    end else if (m_phase == 4) begin
      if (pwm_raw) begin m_phase = 3; m_short = 1; end
      else if (m_edge == m_gap_end) m_phase = 1;
    end
    if (load) m_dt = (deadtime_cycles_i == 0) ? 1 : int'(deadtime_cycles_i);
  endtask

  task automatic check_all();
    check_eq("pwm_l", int'(pwm_l), int'(m_phase == 1));
    check_eq("pwm_h", int'(pwm_h), int'(m_phase == 3));
    check_eq("in_deadtime", int'(in_deadtime), int'(m_phase == 2 || m_phase == 4));
    check_eq("short_pulse", int'(short_pulse), m_short);
    check_eq("dt_active", int'(dt_active), m_dt);
    check_eq("no_overlap", int'(pwm_h & pwm_l), 0);
  endtask

  // Drive inputs, take one edge, update model, compare just after the edge.
  task automatic cycle(input bit en, input bit raw, input bit pe, input int dt);
    enable            = en;
    pwm_raw           = raw;
    period_end        = pe;
    deadtime_cycles_i = DTW'(dt);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asynchronous reset mid-cycle, held across one edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_pwm_h", int'(pwm_h), 0);
    check_eq("rst_pwm_l", int'(pwm_l), 0);
    check_eq("rst_in_dt", int'(in_deadtime), 0);
    check_eq("rst_short", int'(short_pulse), 0);
    check_eq("rst_dt_active", int'(dt_active), 2);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt_dt, cnt_sp, cnt_h;
    int per_len, per_cnt, hold, dt_req, en_off;
    bit raw_r;

    rst = 1'b1; enable = 1'b0; pwm_raw = 1'b0; period_end = 1'b0;
    deadtime_cycles_i = DTW'(3);
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Enable from idle with pwm_raw low: low gate next edge, shadow takes 3.
    cycle(1, 0, 0, 3);
    check_eq("t1_pwm_l", int'(pwm_l), 1);
    check_eq("t1_dt_active", int'(dt_active), 3);
    repeat (3) cycle(1, 0, 0, 3);

    // Rising edge with dead time 3.
    cnt_dt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0, 3);
      cnt_dt += int'(in_deadtime);
      if (i == 0) check_eq("t2_l_fall", int'(pwm_l), 0);
      if (i == 2) check_eq("t2_h_early", int'(pwm_h), 0);
      if (i == 3) check_eq("t2_h_rise", int'(pwm_h), 1);
    end
    check_eq("t2_rise_gap", cnt_dt, 3);
    cnt_dt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 3);
      cnt_dt += int'(in_deadtime);
      if (i == 3) check_eq("t2_l_rise", int'(pwm_l), 1);
    end
    check_eq("t2_fall_gap", cnt_dt, 3);

    // Short high pulse inside a 4-cycle gap aborts back to low.
    cycle(1, 0, 1, 4);
    check_eq("t3_dt_active", int'(dt_active), 4);
    cnt_sp = 0; cnt_h = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, (i < 2), 0, 4);
      cnt_sp += int'(short_pulse);
      cnt_h  += int'(pwm_h);
    end
    check_eq("t3_short_cnt", cnt_sp, 1);
    check_eq("t3_h_never", cnt_h, 0);
    check_eq("t3_l_back", int'(pwm_l), 1);

    // Mid-period request change only takes effect at the next period boundary.
    cycle(1, 0, 1, 3);
    repeat (2) cycle(1, 0, 0, 6);
    check_eq("t4_dt_hold", int'(dt_active), 3);
    cnt_dt = 0;
    for (int i = 0; i < 5; i++) begin cycle(1, 1, 0, 6); cnt_dt += int'(in_deadtime); end
    check_eq("t4_old_gap", cnt_dt, 3);
    cycle(1, 1, 1, 6);
    check_eq("t4_dt_new", int'(dt_active), 6);
    cnt_dt = 0;
    for (int i = 0; i < 9; i++) begin cycle(1, 0, 0, 6); cnt_dt += int'(in_deadtime); end
    check_eq("t4_new_gap", cnt_dt, 6);

    // Zero request clamps to a one-cycle gap.
    cycle(1, 0, 1, 0);
    check_eq("t5_dt_clamp", int'(dt_active), 1);
    cycle(1, 1, 0, 0);
    check_eq("t5_gap_dt", int'(in_deadtime), 1);
    cycle(1, 1, 0, 0);
    check_eq("t5_h_on", int'(pwm_h), 1);

    // Drop enable inside a gap, re-enable high, then reset while high.
    repeat (2) cycle(1, 0, 1, 4);
    cycle(1, 1, 0, 4);
    cycle(0, 1, 0, 4);
    check_eq("t6_off_h", int'(pwm_h), 0);
    check_eq("t6_off_l", int'(pwm_l), 0);
    cycle(1, 1, 0, 4);
    check_eq("t6_reen_h", int'(pwm_h), 1);
    do_reset();
    cycle(1, 1, 0, 4);
    check_eq("t6_post_rst_h", int'(pwm_h), 1);

    // Randomized traffic.
    per_len = 10; per_cnt = 0; hold = 0; raw_r = 1'b0; dt_req = 3; en_off = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin raw_r = ~raw_r; hold = $urandom_range(1, 10); end
      hold--;
      if ($urandom_range(0, 19) == 0) dt_req = $urandom_range(0, 6);
      if (en_off == 0 && $urandom_range(0, 99) == 0) en_off = $urandom_range(1, 5);
      cycle((en_off == 0), raw_r, (per_cnt == per_len - 1), dt_req);
      if (en_off > 0) en_off--;
      if (per_cnt == per_len - 1) begin per_cnt = 0; per_len = $urandom_range(6, 20); end
      else per_cnt++;
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pwm_deadtime_ip
